// File: rtl/avalon_burst_responder.sv
// Avalon-MM pipelined burst slave backed by a word-addressed register memory.
// Accepts write bursts (with stall support) and read bursts with a fixed,
// parameterised latency from command accept to the first readdatavalid beat.
//
// Handshake: a command is accepted on a rising edge where read or write is
// high and waitrequest is low. waitrequest is a register (decode of the next
// state), so there is no combinational path from any input to it. Read beats
// are pushed with readdatavalid; the master cannot back-pressure them.
module avalon_burst_responder #(
  parameter int DEPTH        = 64,
  parameter int READ_LATENCY = 2,
  parameter int MAX_BURST    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [4:0]  burstcount,
  input  logic [3:0]  byteenable,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        readdatavalid,
  output logic        waitrequest,
  output logic        protocol_err,
  output logic [1:0]  state_dbg
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WR_BURST = 2'd1;
  localparam logic [1:0] S_RD_LAT   = 2'd2;
  localparam logic [1:0] S_RD_BURST = 2'd3;

  localparam logic [4:0] MAX_BC   = 5'(MAX_BURST);
  // RD_LAT is occupied for READ_LATENCY-1 cycles; the counter runs down to 0.
  localparam logic [3:0] LAT_INIT = 4'((READ_LATENCY >= 2) ? (READ_LATENCY - 2) : 0);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [4:0]    rem_q, rem_d;
  logic [3:0]    lat_q, lat_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rdv_q, rdv_d;
  logic          wait_q, wait_d;
  logic          err_q, err_d;

  logic [31:0]   mem_q [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;

  logic [AW-1:0] addr_idx;
  logic [4:0]    bc_nz;
  logic          bc_over;
  logic [4:0]    bc_eff;
  logic          unused_addr_bits;

  assign addr_idx         = address[AW+1:2];
  assign unused_addr_bits = ^{address[31:AW+2], address[1:0]};

  // Burst length after the 0->1 conversion and the clamp to MAX_BURST.
  always_comb begin
    bc_nz   = (burstcount == 5'd0) ? 5'd1 : burstcount;
    bc_over = (bc_nz > MAX_BC);
    bc_eff  = bc_over ? MAX_BC : bc_nz;
  end

  // Next-state, pointer/counter and read-beat launch logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    lat_d     = lat_q;
    rdata_d   = rdata_q;
    rdv_d     = 1'b0;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (!wait_q) begin
          if (write) begin
            // Write wins over a simultaneous read; the read is dropped.
            mem_we    = 1'b1;
            mem_waddr = addr_idx;
            ptr_d     = addr_idx + 1'b1;
            rem_d     = bc_eff - 5'd1;
            if (bc_over || read) err_d = 1'b1;
            if (bc_eff != 5'd1) state_d = S_WR_BURST;
          end else if (read) begin
            ptr_d = addr_idx;
            rem_d = bc_eff;
            if (bc_over) err_d = 1'b1;
            if (READ_LATENCY <= 1) begin
              state_d = S_RD_BURST;
            end else begin
              state_d = S_RD_LAT;
              lat_d   = LAT_INIT;
            end
          end
        end
      end
      S_WR_BURST: begin
        if (read) err_d = 1'b1;
        if (write) begin
          mem_we    = 1'b1;
          mem_waddr = ptr_q;
          ptr_d     = ptr_q + 1'b1;
          rem_d     = rem_q - 5'd1;
          if (rem_q == 5'd1) state_d = S_IDLE;
        end
      end
      S_RD_LAT: begin
        if (lat_q == 4'd0) state_d = S_RD_BURST;
        else               lat_d   = lat_q - 4'd1;
      end
      default: begin
        // S_RD_BURST: launch one beat per cycle from the memory as it is now.
        rdata_d = mem_q[ptr_q];
        rdv_d   = 1'b1;
        ptr_d   = ptr_q + 1'b1;
        rem_d   = rem_q - 5'd1;
        if (rem_q == 5'd1) state_d = S_IDLE;
      end
    endcase
    wait_d = (state_d == S_RD_LAT) || (state_d == S_RD_BURST);
  end

  // Control and output registers; reset abandons any burst in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= 5'd0;
      lat_q   <= 4'd0;
      rdata_q <= 32'd0;
      rdv_q   <= 1'b0;
      wait_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      lat_q   <= lat_d;
      rdata_q <= rdata_d;
      rdv_q   <= rdv_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  // Memory array with per-byte write enables; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b]) mem_q[mem_waddr][8*b +: 8] <= writedata[8*b +: 8];
      end
    end
  end

  assign readdata      = rdata_q;
  assign readdatavalid = rdv_q;
  assign waitrequest   = wait_q;
  assign protocol_err  = err_q;
  assign state_dbg     = state_q;

endmodule

// File: doc/avalon_burst_responder.md
Name: avalon_burst_responder

Overview:
- Avalon-MM pipelined burst slave backed by a local word-addressed register memory.
- Sits on the far side of the Blitter's master port; answers its read bursts (sprite and frame fetch) and write bursts (frame stores).
- Gives the Blitter a deterministic, latency-configurable target for bring-up and simulation without SDRAM.

Parameters:
DEPTH, 64, number of 32-bit words in the memory; power of two
READ_LATENCY, 2, cycles from read-command accept to first readdatavalid beat; legal range 1..8
MAX_BURST, 16, largest legal burstcount; burstcount values above this are clamped to it

Ports:
clk  input  1  system clock, all state on the rising edge
reset  input  1  asynchronous, active-high reset
address  input  32  byte address; word index = address[log2(DEPTH)+1:2], upper bits ignored (wraps modulo DEPTH)
burstcount  input  5  beats in the burst; 0 is treated as 1
byteenable  input  4  per-byte write mask; ignored for reads
read  input  1  read command
write  input  1  write command / write beat
writedata  input  32  write beat data
readdata  output  32  read beat data, registered
readdatavalid  output  1  read beat valid, registered
waitrequest  output  1  command stall, decoded from the state register only (no input-to-output combinational path)
protocol_err  output  1  sticky error flag, cleared only by reset

Behaviour:
- Reset values: state IDLE, readdata 0, readdatavalid 0, waitrequest 1, protocol_err 0, beat and latency counters 0. Memory contents are not reset.
- Reset mid-burst: the burst is abandoned immediately. Writes already committed persist. No further readdatavalid beats are issued after reset deasserts.
- States: IDLE, WR_BURST, RD_LAT, RD_BURST.
- waitrequest: 0 in IDLE and WR_BURST; 1 in RD_LAT, RD_BURST and during reset.
- A command is accepted at a rising edge where it is asserted and waitrequest is 0.
- IDLE, write accepted:
  - Beat 0 is written to word A = address word index, honouring byteenable.
  - remaining = burstcount − 1 (after 0→1 conversion and clamping to MAX_BURST).
  - remaining = 0: stay in IDLE. Otherwise go to WR_BURST.
- WR_BURST, per cycle:
  - write=1: write the next sequential word (A+1, A+2, … mod DEPTH), decrement remaining, return to IDLE when remaining reaches 0.
  - write=0: stall in WR_BURST and hold state.
  - address and burstcount are ignored on beats after the first.
- IDLE, read accepted:
  - Latch A and N = burstcount (after 0→1 conversion and clamping).
  - Go to RD_LAT with a latency counter.
  - First readdatavalid occurs exactly READ_LATENCY cycles after the accept edge.
  - Then N consecutive beats with no gaps, returning mem[A], mem[A+1], … mod DEPTH.
  - Enter IDLE on the edge that launches the last beat; waitrequest drops together with that beat.
- read and write both asserted in IDLE: the write is accepted, the read is ignored, protocol_err is set.
- read asserted in WR_BURST: ignored, protocol_err is set.
- Read data during a read burst is sampled from memory as it stands when each beat is launched.
- Any burstcount > MAX_BURST sets protocol_err (and is clamped).
- readdata holds its last value when readdatavalid = 0.
- Address offset bits [1:0] are ignored.

Test Plan:
- Reset: assert reset mid-simulation → waitrequest=1, readdatavalid=0, protocol_err=0. Release → waitrequest=0 next cycle.
- Single write, then read:
  - Write 0xDEADBEEF to 0x00000008 with burstcount=1, byteenable=0xF.
  - Read 0x00000008 with burstcount=1 and READ_LATENCY=2 → readdatavalid=1 with readdata=0xDEADBEEF exactly 2 cycles after the accept edge.
- Burst write with stalls, then burst read:
  - 4-beat write at 0x00000010 with data 0x11, 0x22, 0x33, 0x44, and write=0 held for 2 cycles between beats 2 and 3.
  - 4-beat read of the same address → 4 consecutive valid beats 0x11, 0x22, 0x33, 0x44; waitrequest=1 from the accept edge through the last beat.
- Byteenable and wrap:
  - With DEPTH=64, write 0xAABBCCDD with byteenable=0x5 over a word preloaded with 0x11223344 → word = 0x11BB33DD.
  - 3-beat read at 0x000000FC → returns words 63, 0, 1.
- Blitter-style address: read at 0x10000000 with burstcount=0 → exactly one beat, from word 0.
- Errors and reset mid-read:
  - read and write asserted together in IDLE → write committed, no read beats, protocol_err=1.
  - Reset pulse during RD_BURST of N=8 after 3 beats → no further beats, state IDLE.
